// File: rtl/fetch_unit.sv
// fetch_unit: multicycle IF stage; owns PC and IR, decodes IR fields,
// and resolves the next PC (sequential/branch/jump) on instr_done.
// Ports:
//   clk, rst            clock, sync active-high reset
//   run                 fetch enable
//   instr_done          control FSM finished the instruction in ir
//   branch_taken        datapath branch compare result
//   instr_in            imem data for pc_out
//   pc_out              imem address
//   ir, ir_pc           latched instruction and its fetch PC
//   opcode,rd,rs,rt,imm decode fields of ir
//   ir_valid            high in EXEC
//   is_jump, is_branch  control-flow class of ir
//   retired_count       instructions completed since reset
module fetch_unit #(
  parameter int PC_WIDTH = 16,
  parameter int INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   instr_done,
  input  logic                   branch_taken,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic [PC_WIDTH-1:0]    ir_pc,
  output logic [5:0]             opcode,
  output logic [4:0]             rd,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic [15:0]            imm,
  output logic                   ir_valid,
  output logic                   is_jump,
  output logic                   is_branch,
  output logic [31:0]            retired_count
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC
  } state_t;

  state_t state, state_n;

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] off;
  logic [PC_WIDTH-1:0] tgt;
  logic                redirect;

  assign opcode = ir[31:26];
  assign rd     = ir[25:21];
  assign rs     = ir[20:16];
  assign rt     = ir[15:11];
  assign imm    = ir[15:0];

  assign is_jump   = (opcode == 6'b000001);
  assign is_branch = opcode inside {6'b100001, 6'b100010, 6'b100011};

  assign pc_out   = pc;
  assign ir_valid = (state == EXEC);

  // Target is relative to the sequential PC; the adder wraps mod 2^W.
  assign off      = PC_WIDTH'(signed'(imm));
  assign seq_pc   = ir_pc + PC_WIDTH'(1);
  assign tgt      = seq_pc + off;
  assign redirect = is_jump | (is_branch & branch_taken);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (run) state_n = FETCH;
      FETCH:   state_n = EXEC;
      EXEC:    if (instr_done) state_n = run ? FETCH : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      ir            <= '0;
      ir_pc         <= '0;
      retired_count <= '0;
    end else begin
      state <= state_n;
      if (state == FETCH) begin
        ir    <= instr_in;
        ir_pc <= pc;
        pc    <= pc + PC_WIDTH'(1);
      end
      // pc already holds ir_pc+1 here; only a redirect overrides it.
      if (state == EXEC && instr_done) begin
        retired_count <= retired_count + 32'd1;
        if (redirect) pc <= tgt;
      end
    end
  end

endmodule
